// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width/sign codes, request legality check and store lane merge.
package mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // A request is an error when its funct3 is not a legal width code for its
  // direction, or when the address is not aligned to the access width.
  function automatic logic req_is_err(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic err;
    err = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = lo[0];
        F3_SW:   err = (lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = lo[0];
        F3_LW:         err = (lo != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

  // Read-modify-write merge for sub-word stores: only the addressed byte or
  // halfword of the captured memory word is replaced.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [31:0] w;
    w = word;
    case (f3)
      F3_SB: begin
        case (lo)
          2'd0:    w[7:0]   = wdata[7:0];
          2'd1:    w[15:8]  = wdata[7:0];
          2'd2:    w[23:16] = wdata[7:0];
          default: w[31:24] = wdata[7:0];
        endcase
      end
      F3_SH: begin
        if (lo[1]) w[31:16] = wdata[15:0];
        else       w[15:0]  = wdata[15:0];
      end
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and extension.
// Ports:
//   word    - 32-bit memory word containing the addressed data
//   addr_lo - byte offset within the word (addr[1:0])
//   funct3  - RV32I load width/sign code
//   result  - sign/zero-extended load value (0 for non-load codes)
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = word;
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between an RV32I core and a word-wide
// synchronous data memory. Sub-word stores use read-modify-write.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_valid/ready - request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr, req_wdata - request fields
//   resp_valid      - one-cycle completion pulse
//   resp_rdata      - extended load data (0 unless successful load)
//   resp_err        - misaligned / illegal funct3, valid with resp_valid
//   mem_addr, mem_ren, mem_wen, mem_wdata - memory command
//   mem_rdata       - memory read data, valid the cycle after mem_ren
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t              state, state_nxt;
  logic                accept;
  logic                req_err;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         word_q;
  logic [31:0]         load_data;

  // Address bits above the memory range are architecturally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  assign req_err = req_is_err(req_we, req_funct3, req_addr[1:0]);

  mem_load_align u_align (
    .word    (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[MEM_AW+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state == S_WAIT) begin
        word_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: begin
        // Ready is gated by rst so it reads 0 for the whole reset pulse.
        req_ready = !rst;
        accept    = req_valid && !rst;
        if (accept) begin
          if (req_err)                         state_nxt = S_RESP;
          else if (req_we && req_funct3 == F3_SW) state_nxt = S_WR;
          else                                 state_nxt = S_RD;
        end
      end
      S_RD: begin
        mem_ren   = 1'b1;
        mem_addr  = addr_q[MEM_AW+1:2];
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = we_q ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_wen   = 1'b1;
        mem_addr  = addr_q[MEM_AW+1:2];
        mem_wdata = store_merge(word_q, wdata_q, f3_q, addr_q[1:0]);
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) resp_rdata = load_data;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic          mem_wen;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous memory model with a backdoor write port for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_cnt <= wen_cnt + 1;
    end
    if (mem_ren) begin
      mem_rdata <= mem[mem_addr];
      ren_cnt <= ren_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one request, then scramble the request inputs and wait (bounded)
  // for resp_valid. lat counts edges from the accept edge (accept edge = 1).
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = '1; req_wdata = '0;
    lat = 0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          r0, w0;
  logic        rv_log [1:8];
  logic        rdy_log [1:8];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;

    bd_write(10'd5,  32'hDEADBEEF);
    bd_write(10'd6,  32'h80FF7F01);
    bd_write(10'd7,  32'h11223344);
    bd_write(10'd9,  32'h00000000);
    bd_write(10'd10, 32'h01020304);

    // Outputs held at zero during reset, even with a request presented.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h14; req_funct3 = 3'b010;
    #1;
    chk("rst_ready",  {31'd0, req_ready},  32'd0);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rerr",   {31'd0, resp_err},   32'd0);
    chk("rst_rdata",  resp_rdata,          32'd0);
    chk("rst_ren",    {31'd0, mem_ren},    32'd0);
    chk("rst_wen",    {31'd0, mem_wen},    32'd0);
    chk("rst_maddr",  {22'd0, mem_addr},   32'd0);
    chk("rst_mwdata", mem_wdata,           32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // LW word 5
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err",  {31'd0, er}, 32'd0);
    chk("lw_lat",  lat, 32'd3);

    // High address bits ignored
    do_req(1'b0, 3'b010, 32'h1000_0014, 32'h0, rd, er, lat);
    chk("lw_hi_data", rd, 32'hDEADBEEF);

    // Byte / halfword loads from 0x80FF7F01
    do_req(1'b0, 3'b000, 32'h1B, 32'h0, rd, er, lat);
    chk("lb_b3", rd, 32'hFFFFFF80);
    chk("lb_lat", lat, 32'd3);
    do_req(1'b0, 3'b100, 32'h1B, 32'h0, rd, er, lat);
    chk("lbu_b3", rd, 32'h00000080);
    do_req(1'b0, 3'b000, 32'h19, 32'h0, rd, er, lat);
    chk("lb_b1", rd, 32'h0000007F);
    do_req(1'b0, 3'b001, 32'h1A, 32'h0, rd, er, lat);
    chk("lh_hi", rd, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 32'h18, 32'h0, rd, er, lat);
    chk("lhu_lo", rd, 32'h00007F01);

    // SB lane 2 into 0x11223344
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b1, 3'b000, 32'h1E, 32'h123456AA, rd, er, lat);
    chk("sb_lat",  lat, 32'd4);
    chk("sb_err",  {31'd0, er}, 32'd0);
    chk("sb_rdata", rd, 32'd0);
    chk("sb_mem",  mem[7], 32'h11AA3344);
    chk("sb_wen",  wen_cnt - w0, 32'd1);
    chk("sb_ren",  ren_cnt - r0, 32'd1);

    // SH low then high halfword
    do_req(1'b1, 3'b001, 32'h1C, 32'hBEEF5555, rd, er, lat);
    chk("sh_lat", lat, 32'd4);
    chk("sh_lo_mem", mem[7], 32'h11AA5555);
    do_req(1'b1, 3'b001, 32'h1E, 32'h00007777, rd, er, lat);
    chk("sh_hi_mem", mem[7], 32'h77775555);

    // SW: no read, 2-cycle latency
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, rd, er, lat);
    chk("sw_lat", lat, 32'd2);
    chk("sw_mem", mem[9], 32'hCAFEF00D);
    chk("sw_ren", ren_cnt - r0, 32'd0);
    chk("sw_wen", wen_cnt - w0, 32'd1);

    // Errors: no memory access, 1-cycle latency
    r0 = ren_cnt; w0 = wen_cnt;
    do_req(1'b1, 3'b001, 32'h3, 32'hFFFF, rd, er, lat);
    chk("sh_mis_err", {31'd0, er}, 32'd1);
    chk("sh_mis_lat", lat, 32'd1);
    do_req(1'b0, 3'b010, 32'h2, 32'h0, rd, er, lat);
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_lat", lat, 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat);
    chk("ld_f3_011_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 3'b110, 32'h0, 32'h0, rd, er, lat);
    chk("ld_f3_110_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b011, 32'h0, 32'h0, rd, er, lat);
    chk("st_f3_011_err", {31'd0, er}, 32'd1);
    chk("err_ren", ren_cnt - r0, 32'd0);
    chk("err_wen", wen_cnt - w0, 32'd0);
    chk("err_mem0", mem[9], 32'hCAFEF00D);

    // Reset during WAIT of an SH to word 10
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h2A; req_wdata = 32'h0000FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    w0 = wen_cnt;
    rst = 1'b1;
    #1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd0);
    chk("rstw_wen",   {31'd0, mem_wen},   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rstw_no_write", wen_cnt - w0, 32'd0);
    chk("rstw_mem", mem[10], 32'h01020304);
    chk("rstw_rvalid", {31'd0, resp_valid}, 32'd0);

    do_req(1'b0, 3'b010, 32'h28, 32'h0, rd, er, lat);
    chk("post_rst_lw", rd, 32'h01020304);
    chk("post_rst_lat", lat, 32'd3);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      rv_log[i]  = resp_valid;
      rdy_log[i] = req_ready;
    end
    req_valid = 1'b0;
    chk("b2b_resp1",  {31'd0, rv_log[3]},  32'd1);
    chk("b2b_rdy_t2", {31'd0, rdy_log[2]}, 32'd0);
    chk("b2b_rdy_t3", {31'd0, rdy_log[3]}, 32'd0);
    chk("b2b_rdy_t4", {31'd0, rdy_log[4]}, 32'd1);
    chk("b2b_rdy_t5", {31'd0, rdy_log[5]}, 32'd0);
    chk("b2b_resp_t6", {31'd0, rv_log[6]}, 32'd0);
    chk("b2b_resp2",  {31'd0, rv_log[7]},  32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_idle", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL provide parameter MEM_AW, default 10, word-address width of the data memory (1024 x 32-bit words).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL provide port req_ready  output  1  unit can accept a request.
REQ-006 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port req_funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL provide port req_addr  input  32  byte address (rs1 + imm).
REQ-009 SHALL provide port req_wdata  input  32  store data (rs2 value, low bytes used for SB/SH).
REQ-010 SHALL provide port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port resp_rdata  output  32  extended load data; 0 unless resp_valid on a successful load.
REQ-012 SHALL provide port resp_err  output  1  misaligned or illegal funct3; valid with resp_valid.
REQ-013 SHALL provide ports mem_addr  output  MEM_AW  word address; mem_ren  output  1; mem_wen  output  1; mem_wdata  output  32; mem_rdata  input  32, valid the cycle after mem_ren.

Function
REQ-014 SHALL accept a request only when req_valid && req_ready on a rising edge, registering we, funct3, addr, wdata; req_ready SHALL be 1 only in IDLE.
REQ-015 SHALL implement FSM states IDLE, RD, WAIT, WR, RESP; accept -> RD for loads, SB, SH; accept -> WR for SW; accept -> RESP for errors.
REQ-016 SHALL drive mem_ren=1 only in RD, mem_wen=1 only in WR; mem_addr = registered addr[MEM_AW+1:2] in RD/WR, 0 otherwise; addr bits above MEM_AW+1 ignored.
REQ-017 SHALL go RD -> WAIT; in WAIT capture mem_rdata; load: WAIT -> RESP; SB/SH: WAIT -> WR.
REQ-018 SHALL, in WR, drive mem_wdata = captured word with only the addressed byte (SB, lane addr[1:0]) or halfword (SH, lane addr[1]) replaced by wdata[7:0]/wdata[15:0]; SW writes wdata unchanged; then WR -> RESP.
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-020 SHALL give latencies from accept edge to resp_valid: load 3 cycles, SW 2 cycles, SB/SH 4 cycles, error 1 cycle.
REQ-021 SHALL extend load data: LB/LH sign-extend, LBU/LHU zero-extend selected lane, LW passes word.
REQ-022 SHALL flag resp_err=1 with no memory access when LH/LHU/SH has addr[0]=1, LW/SW has addr[1:0]!=0, a load uses funct3 011/110/111, or a store uses funct3 >010.
REQ-023 SHALL ignore req_valid when not in IDLE; request inputs may change freely after acceptance.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, all registers 0, and outputs req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-025 SHALL abort any in-flight access on rst assertion mid-operation with no write issued after the reset edge; req_ready=1 the first cycle after rst deasserts.

Structure
REQ-026 SHALL place the FSM state enum and funct3 constants (LB..LHU, SB..SW) in shared package mem_access_pkg.
REQ-027 SHALL implement lane selection/extension in combinational sub-module mem_load_align (inputs word, addr[1:0], funct3; output 32-bit result).

Verification
REQ-028 SHALL test LW: mem word 5 = 0xDEADBEEF, request addr 0x14 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after accept.
REQ-029 SHALL test LB/LBU: word 0x80FF7F01, addr byte 3 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-030 SHALL test SB: word 0x11223344, SB addr[1:0]=2, wdata 0xAA -> memory word 0x11AA3344, one mem_wen pulse, resp 4 cycles after accept.
REQ-031 SHALL test misaligned SH addr 0x3 and LW addr 0x2 -> resp_err 1 next cycle, mem_ren/mem_wen never asserted.
REQ-032 SHALL test rst asserted during WAIT of an SH -> no mem_wen, req_ready 1 the cycle after rst deasserts, target word unchanged.
REQ-033 SHALL test back-to-back requests with req_valid held high -> second accepted only the cycle after first resp_valid.
